// File: rtl/dht11_sensor_model.sv
// DHT11 sensor-side responder: answers a host start pulse with the sync
// handshake and a 40-bit humidity/temperature frame on an open-drain line.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   rh_int     humidity integer byte
//   rh_dec     humidity decimal byte
//   t_int      temperature integer byte
//   t_dec      temperature decimal byte
//   cs_err     1 = send checksum with bit0 inverted
//   dht11_io   open-drain data line (drives 0 or releases)
//   busy       high from start detection until the end pulse completes
//   frame_done one-clock pulse when the end pulse finishes
//   state_led  current FSM state encoding

module dht11_sensor_model #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int START_MIN_US = 10000,
    parameter int T_GO_US      = 30,
    parameter int T_RESP_US    = 80,
    parameter int T_BITL_US    = 50,
    parameter int T_ZERO_US    = 26,
    parameter int T_ONE_US     = 70
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rh_int,
    input  logic [7:0] rh_dec,
    input  logic [7:0] t_int,
    input  logic [7:0] t_dec,
    input  logic       cs_err,
    inout  wire        dht11_io,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] state_led
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    // Timer must hold the longest duration any state waits for.
    localparam int M1   = (START_MIN_US > T_RESP_US) ? START_MIN_US : T_RESP_US;
    localparam int M2   = (M1 > T_BITL_US) ? M1 : T_BITL_US;
    localparam int M3   = (M2 > T_ONE_US) ? M2 : T_ONE_US;
    localparam int M4   = (M3 > T_ZERO_US) ? M3 : T_ZERO_US;
    localparam int TMAX = (M4 > T_GO_US) ? M4 : T_GO_US;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HOST_LOW = 3'd1,
        S_HOST_REL = 3'd2,
        S_RESP_L   = 3'd3,
        S_RESP_H   = 3'd4,
        S_BIT_L    = 3'd5,
        S_BIT_H    = 3'd6,
        S_END_L    = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [39:0]   shadow_q, shadow_d;
    logic [5:0]    bitcnt_q, bitcnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          oe_q, oe_d;
    logic [1:0]    sync_q;

    logic          line;
    logic          tick;
    logic          go_done;
    logic          resp_done;
    logic          bitl_done;
    logic          one_done;
    logic          zero_done;
    logic          cur_bit;
    logic [7:0]    cs;

    assign dht11_io = oe_q ? 1'b0 : 1'bz;

    assign line = sync_q[1];
    assign tick = (pre_q == PW'(DIV - 1));

    // A timed state ends on the tick where the timer reads DUR-1.
    assign go_done   = tick && (timer_q == TW'(T_GO_US - 1));
    assign resp_done = tick && (timer_q == TW'(T_RESP_US - 1));
    assign bitl_done = tick && (timer_q == TW'(T_BITL_US - 1));
    assign one_done  = tick && (timer_q == TW'(T_ONE_US - 1));
    assign zero_done = tick && (timer_q == TW'(T_ZERO_US - 1));

    assign cur_bit = shadow_q[6'd39 - bitcnt_q];
    assign cs      = (rh_int + rh_dec + t_int + t_dec) ^ {7'd0, cs_err};

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], dht11_io};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            pre_q    <= '0;
            shadow_q <= '0;
            bitcnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pre_q    <= pre_d;
            shadow_q <= shadow_d;
            bitcnt_q <= bitcnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            oe_q     <= oe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        bitcnt_d = bitcnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pre_d    = tick ? '0 : pre_q + 1'b1;
        timer_d  = timer_q;
        // Saturating count keeps the host-low measurement valid past START_MIN.
        if (tick && (timer_q != TW'(TMAX))) begin
            timer_d = timer_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!line) begin
                    state_d = S_HOST_LOW;
                end
            end
            S_HOST_LOW: begin
                if (line) begin
                    if (timer_q >= TW'(START_MIN_US)) begin
                        state_d  = S_HOST_REL;
                        shadow_d = {rh_int, rh_dec, t_int, t_dec, cs};
                        busy_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOST_REL: begin
                if (go_done) begin
                    state_d = S_RESP_L;
                end
            end
            S_RESP_L: begin
                if (resp_done) begin
                    state_d = S_RESP_H;
                end
            end
            S_RESP_H: begin
                if (resp_done) begin
                    state_d  = S_BIT_L;
                    bitcnt_d = '0;
                end
            end
            S_BIT_L: begin
                if (bitl_done) begin
                    state_d = S_BIT_H;
                end
            end
            S_BIT_H: begin
                if (cur_bit ? one_done : zero_done) begin
                    if (bitcnt_q == 6'd39) begin
                        state_d = S_END_L;
                    end else begin
                        state_d  = S_BIT_L;
                        bitcnt_d = bitcnt_q + 6'd1;
                    end
                end
            end
            S_END_L: begin
                if (bitl_done) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end

        // Registered drive enable follows the next state, so the pin
        // changes on the same edge as the state and never glitches.
        oe_d = (state_d == S_RESP_L) || (state_d == S_BIT_L) ||
               (state_d == S_END_L);
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign state_led  = state_q;

endmodule

// File: tb/tb_dht11_sensor_model.sv
// Bench for dht11_sensor_model: plays the host side of the bus, measures
// every pulse width and decodes the frame against a reference model.
`timescale 1ns/1ps

module tb_dht11_sensor_model;

    localparam int CLK_HZ    = 2_000_000;
    localparam int CPU       = 2;
    localparam int START_MIN = 200;
    localparam int LONG_US   = 360;
    localparam int SHORT_US  = 100;
    localparam int T_GO      = 30;
    localparam int T_RESP    = 80;
    localparam int T_BITL    = 50;
    localparam int T_ZERO    = 26;
    localparam int T_ONE     = 70;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rh_int, rh_dec, t_int, t_dec;
    logic       cs_err;
    logic       host_drv;
    wire        dht11_io;
    logic       busy, frame_done;
    logic [2:0] state_led;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;

    always #250 clk = ~clk;

    assign dht11_io = host_drv ? 1'b0 : 1'bz;
    pullup (dht11_io);

    dht11_sensor_model #(
        .CLK_HZ(CLK_HZ), .START_MIN_US(START_MIN), .T_GO_US(T_GO),
        .T_RESP_US(T_RESP), .T_BITL_US(T_BITL), .T_ZERO_US(T_ZERO),
        .T_ONE_US(T_ONE)
    ) dut (
        .clk(clk), .rst(rst), .rh_int(rh_int), .rh_dec(rh_dec),
        .t_int(t_int), .t_dec(t_dec), .cs_err(cs_err),
        .dht11_io(dht11_io), .busy(busy), .frame_done(frame_done),
        .state_led(state_led)
    );

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    function automatic logic [39:0] ref_frame(input logic [7:0] a, b, c, d,
                                              input logic err);
        int s;
        s = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
        if (err) s = s ^ 1;
        return {a, b, c, d, 8'(s)};
    endfunction

    // Host start pulse, then run-length capture of the reply. Widths are
    // compared to the expected frame; bits are decoded by a 48 us threshold.
    task automatic host_frame(input int low_us, input logic [39:0] exp,
                              input int chg_low, input logic [7:0] chg_val,
                              output logic [39:0] got, output int werr,
                              output int nseg, output bit tmo,
                              output int bclk);
        int len, lvl, v, nh, nl, budget, w, lo, hi, k;
        got = '0; werr = 0; tmo = 0; bclk = 0; nh = 0; nl = 0;
        @(negedge clk);
        host_drv = 1'b1;
        repeat (low_us * CPU) @(negedge clk);
        host_drv = 1'b0;
        lvl = 1; len = 0; budget = 0;
        forever begin
            @(negedge clk);
            budget++;
            if (busy === 1'b1) bclk++;
            v = (dht11_io === 1'b0) ? 0 : 1;
            if (v == lvl) begin
                len++;
            end else begin
                if (lvl == 1) begin
                    if (nh == 0) begin
                        lo = CPU * T_GO - 2; hi = CPU * T_GO + 4;
                    end else if (nh == 1) begin
                        lo = CPU * T_RESP - 2; hi = CPU * T_RESP + 2;
                    end else begin
                        k = nh - 2;
                        if (k < 40) begin
                            w = exp[39-k] ? T_ONE : T_ZERO;
                            got[39-k] = (len > CPU * 48);
                        end else begin
                            w = 0;
                        end
                        lo = CPU * w - 2; hi = CPU * w + 2;
                    end
                    nh++;
                end else begin
                    w = (nl == 0) ? T_RESP : T_BITL;
                    lo = CPU * w - 2; hi = CPU * w + 2;
                    nl++;
                end
                if (len < lo || len > hi) werr++;
                if (lvl == 0 && nl == 42) break;
                lvl = v; len = 1;
                if (v == 0 && nl == chg_low) rh_int = chg_val;
            end
            if (budget > 20000) begin
                tmo = 1;
                break;
            end
        end
        nseg = nh + nl;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (state_led !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", state_led);
        end
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got busy=%b done=%b expected 0,0", busy, frame_done);
        end
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (dht11_io !== 1'b1) begin
            errors++; $display("FAIL reset_bus: got %b expected 1", dht11_io);
        end
        checks++;
        if (state_led !== 3'd0 || fd_cnt != 0) begin
            errors++; $display("FAIL reset_idle: got state=%0d fd=%0d expected 0,0", state_led, fd_cnt);
        end
    endtask

    task automatic test_basic;
        logic [39:0] exp, got;
        logic [7:0]  sum;
        int werr, nseg, bclk, fd0;
        bit tmo;
        rh_int = 8'h37; rh_dec = 8'h00; t_int = 8'h19; t_dec = 8'h00; cs_err = 1'b0;
        exp = ref_frame(rh_int, rh_dec, t_int, t_dec, cs_err);
        fd0 = fd_cnt;
        host_frame(LONG_US, exp, -1, 8'h00, got, werr, nseg, tmo, bclk);
        repeat (4) @(negedge clk);
        sum = got[39:32] + got[31:24] + got[23:16] + got[15:8];
        checks++;
        if (tmo || nseg != 84) begin
            errors++; $display("FAIL basic_segs: got %0d tmo=%0d expected 84 tmo=0", nseg, tmo);
        end
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL basic_frame: got %h expected %h", got, exp);
        end
        checks++;
        if (werr != 0) begin
            errors++; $display("FAIL basic_widths: got %0d bad widths expected 0", werr);
        end
        checks++;
        if (got[39:32] !== 8'h37 || got[23:16] !== 8'h19 || sum !== got[7:0]) begin
            errors++; $display("FAIL basic_host: got rh=%h t=%h cs=%h expected 37,19,valid", got[39:32], got[23:16], got[7:0]);
        end
        checks++;
        if (got[7:0] !== 8'h50) begin
            errors++; $display("FAIL basic_cs: got %h expected 50", got[7:0]);
        end
        checks++;
        if (fd_cnt - fd0 != 1 || bclk == 0) begin
            errors++; $display("FAIL basic_done: got pulses=%0d busy_clks=%0d expected 1,>0", fd_cnt - fd0, bclk);
        end
        checks++;
        if (busy !== 1'b0 || state_led !== 3'd0) begin
            errors++; $display("FAIL basic_after: got busy=%b state=%0d expected 0,0", busy, state_led);
        end
    endtask

    task automatic test_short_start;
        int dut_low, bseen, fd0;
        dut_low = 0; bseen = 0; fd0 = fd_cnt;
        @(negedge clk);
        host_drv = 1'b1;
        repeat (SHORT_US * CPU) begin
            @(negedge clk);
            if (busy !== 1'b0) bseen++;
        end
        host_drv = 1'b0;
        repeat (400 * CPU) begin
            @(negedge clk);
            if (dht11_io !== 1'b1) dut_low++;
            if (busy !== 1'b0) bseen++;
        end
        checks++;
        if (dut_low != 0) begin
            errors++; $display("FAIL short_bus: got %0d low clks expected 0", dut_low);
        end
        checks++;
        if (bseen != 0 || fd_cnt != fd0) begin
            errors++; $display("FAIL short_busy: got busy=%0d fd=%0d expected 0,0", bseen, fd_cnt - fd0);
        end
        checks++;
        if (state_led !== 3'd0) begin
            errors++; $display("FAIL short_state: got %0d expected 0", state_led);
        end
    endtask

    task automatic test_widths;
        logic [39:0] exp, got;
        int werr, nseg, bclk;
        bit tmo;
        rh_int = 8'hFF; rh_dec = 8'h00; t_int = 8'hFF; t_dec = 8'h00; cs_err = 1'b0;
        exp = ref_frame(rh_int, rh_dec, t_int, t_dec, cs_err);
        host_frame(LONG_US, exp, -1, 8'h00, got, werr, nseg, tmo, bclk);
        repeat (4) @(negedge clk);
        checks++;
        if (tmo || werr != 0) begin
            errors++; $display("FAIL width_ones: got %0d bad widths tmo=%0d expected 0", werr, tmo);
        end
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL width_frame: got %h expected %h", got, exp);
        end
        checks++;
        if (got[7:0] !== 8'hFE) begin
            errors++; $display("FAIL width_cs: got %h expected fe", got[7:0]);
        end
    endtask

    task automatic test_cs_err;
        logic [39:0] exp, got;
        logic [7:0]  sum;
        int werr, nseg, bclk, fd0;
        bit tmo;
        rh_int = 8'h37; rh_dec = 8'h00; t_int = 8'h19; t_dec = 8'h00; cs_err = 1'b1;
        exp = ref_frame(rh_int, rh_dec, t_int, t_dec, cs_err);
        fd0 = fd_cnt;
        host_frame(LONG_US, exp, -1, 8'h00, got, werr, nseg, tmo, bclk);
        repeat (4) @(negedge clk);
        cs_err = 1'b0;
        sum = got[39:32] + got[31:24] + got[23:16] + got[15:8];
        checks++;
        if (tmo || got[7:0] !== 8'h51) begin
            errors++; $display("FAIL cserr_cs: got %h expected 51", got[7:0]);
        end
        checks++;
        if (sum === got[7:0]) begin
            errors++; $display("FAIL cserr_valid: got valid=1 expected 0");
        end
        checks++;
        if (fd_cnt - fd0 != 1) begin
            errors++; $display("FAIL cserr_done: got %0d pulses expected 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_reset_mid;
        logic [39:0] exp, got;
        int werr, nseg, bclk, fd0, nl, lvl, v, budget;
        bit tmo;
        rh_int = 8'h5A; rh_dec = 8'h03; t_int = 8'h21; t_dec = 8'h07; cs_err = 1'b0;
        exp = ref_frame(rh_int, rh_dec, t_int, t_dec, cs_err);
        @(negedge clk);
        host_drv = 1'b1;
        repeat (LONG_US * CPU) @(negedge clk);
        host_drv = 1'b0;
        nl = 0; lvl = 1; budget = 0; tmo = 0;
        // Lows: response, then bit0..; bit 20 high starts after low #22.
        forever begin
            @(negedge clk);
            budget++;
            v = (dht11_io === 1'b0) ? 0 : 1;
            if (lvl == 1 && v == 0) nl++;
            if (lvl == 0 && v == 1 && nl == 22) break;
            lvl = v;
            if (budget > 20000) begin
                tmo = 1;
                break;
            end
        end
        checks++;
        if (tmo) begin
            errors++; $display("FAIL rstmid_reach: got timeout expected bit 20");
        end
        repeat (10) @(negedge clk);
        fd0 = fd_cnt;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dht11_io !== 1'b1 || state_led !== 3'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_state: got bus=%b state=%0d busy=%b expected 1,0,0", dht11_io, state_led, busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (fd_cnt != fd0 || state_led !== 3'd0) begin
            errors++; $display("FAIL rstmid_nodone: got fd=%0d state=%0d expected 0,0", fd_cnt - fd0, state_led);
        end
        host_frame(LONG_US, exp, -1, 8'h00, got, werr, nseg, tmo, bclk);
        repeat (4) @(negedge clk);
        checks++;
        if (tmo || got !== exp || werr != 0) begin
            errors++; $display("FAIL rstmid_next: got %h werr=%0d expected %h", got, werr, exp);
        end
    endtask

    task automatic test_midframe_change;
        logic [39:0] exp, got;
        int werr, nseg, bclk;
        bit tmo;
        rh_int = 8'h37; rh_dec = 8'h00; t_int = 8'h19; t_dec = 8'h00; cs_err = 1'b0;
        exp = ref_frame(rh_int, rh_dec, t_int, t_dec, cs_err);
        host_frame(LONG_US, exp, 4, 8'h40, got, werr, nseg, tmo, bclk);
        repeat (4) @(negedge clk);
        checks++;
        if (tmo || got !== exp || got[39:32] !== 8'h37) begin
            errors++; $display("FAIL change_inflight: got %h expected %h", got, exp);
        end
        exp = ref_frame(8'h40, rh_dec, t_int, t_dec, cs_err);
        host_frame(LONG_US, exp, -1, 8'h00, got, werr, nseg, tmo, bclk);
        repeat (4) @(negedge clk);
        checks++;
        if (tmo || got !== exp || werr != 0) begin
            errors++; $display("FAIL change_next: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_random;
        logic [39:0] exp, got;
        logic [7:0]  sum;
        int werr, nseg, bclk, fd0;
        bit tmo;
        rh_int = 8'($urandom); rh_dec = 8'($urandom);
        t_int  = 8'($urandom); t_dec  = 8'($urandom);
        cs_err = 1'($urandom_range(0, 1));
        exp = ref_frame(rh_int, rh_dec, t_int, t_dec, cs_err);
        fd0 = fd_cnt;
        host_frame(LONG_US, exp, -1, 8'h00, got, werr, nseg, tmo, bclk);
        repeat (4) @(negedge clk);
        sum = got[39:32] + got[31:24] + got[23:16] + got[15:8];
        checks++;
        if (tmo || got !== exp || werr != 0) begin
            errors++; $display("FAIL rand_frame: got %h werr=%0d expected %h", got, werr, exp);
        end
        checks++;
        if ((sum === got[7:0]) !== !cs_err || fd_cnt - fd0 != 1) begin
            errors++; $display("FAIL rand_valid: got valid=%b fd=%0d expected %b,1", sum === got[7:0], fd_cnt - fd0, !cs_err);
        end
        cs_err = 1'b0;
    endtask

    initial begin
        rst = 1'b0; host_drv = 1'b0; cs_err = 1'b0;
        rh_int = 8'h00; rh_dec = 8'h00; t_int = 8'h00; t_dec = 8'h00;
        test_reset;
        test_basic;
        test_short_start;
        test_widths;
        test_cs_err;
        test_reset_mid;
        test_midframe_change;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
